// File: rtl/pst_if_pkg.sv
// Shared definitions for the pst_if instruction-fetch stage.
// Optional performance counters are enabled by the PST_IF_PERF_CNT_EN macro.
package pst_if_pkg;

   // Default width of the word-addressed PC / instruction-memory address.
   localparam int IM_ADDR_NBIT_DEF = 10;

   // Fetch-stage run state: HALTED is entered by a syscall halt.
   typedef enum logic {
      IF_STATE_RUN    = 1'b0,
      IF_STATE_HALTED = 1'b1
   } if_state_e;

   // Instruction word placed in IF/ID for a bubble.
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage : pst_if_pkg

// File: rtl/pst_if_pc_gen.sv
// Next-PC priority mux for the fetch stage: redirect, halt hold, stall hold,
// then sequential increment with wrap at the top of the address space.
module pst_if_pc_gen
   import pst_if_pkg::*;
#(
   parameter int IM_ADDR_NBIT = IM_ADDR_NBIT_DEF
) (
   input  logic [IM_ADDR_NBIT-1:0] pc_i,
   input  logic                    redirect_vld_i,
   input  logic [IM_ADDR_NBIT-1:0] redirect_pc_i,
   input  logic                    halt_req_i,
   input  logic                    stall_i,
   input  if_state_e               state_i,
   output logic [IM_ADDR_NBIT-1:0] pc_next_o
);

   // Select the next PC, highest-priority condition first.
   always_comb begin
      // NOTE: the default is assigned before any branch so every path drives
      // pc_next_o and no latch is inferred.
      pc_next_o = pc_i + IM_ADDR_NBIT'(1);
      if (redirect_vld_i) begin
         pc_next_o = redirect_pc_i;
      end else if ((state_i == IF_STATE_HALTED) || halt_req_i) begin
         pc_next_o = pc_i;
      end else if (stall_i) begin
         pc_next_o = pc_i;
      end
   end

endmodule : pst_if_pc_gen

// File: rtl/pst_if.sv
// Pipelined instruction-fetch stage: owns the PC, the IF/ID register and the
// RUN/HALTED state machine. Instruction memory is read asynchronously.
// Optional perf_fetch / perf_bubble counters: define PST_IF_PERF_CNT_EN.
module pst_if
   import pst_if_pkg::*;
#(
   parameter int                    IM_ADDR_NBIT = IM_ADDR_NBIT_DEF,
   parameter logic [IM_ADDR_NBIT-1:0] RESET_PC   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    stall,
   input  logic                    flush_id,
   input  logic                    redirect_vld,
   input  logic [IM_ADDR_NBIT-1:0] redirect_pc,
   input  logic                    halt_req,
   input  logic                    resume,
   output logic [IM_ADDR_NBIT-1:0] im_addr,
   input  logic [31:0]             im_data,
   output logic [IM_ADDR_NBIT-1:0] id_pc,
   output logic [IM_ADDR_NBIT-1:0] id_pc_next,
   output logic [31:0]             id_inst,
   output logic                    id_vld,
   output logic                    halted
`ifdef PST_IF_PERF_CNT_EN
   ,
   output logic [31:0]             perf_fetch,
   output logic [31:0]             perf_bubble
`endif
);

   logic [IM_ADDR_NBIT-1:0] pc_q, pc_d;
   logic [IM_ADDR_NBIT-1:0] pc_plus1;
   if_state_e               state_q, state_d;
   logic [IM_ADDR_NBIT-1:0] id_pc_q, id_pc_next_q;
   logic [31:0]             id_inst_q;
   logic                    id_vld_q;
   logic                    ld_bubble, ld_real;
   logic                    is_halted;

   assign is_halted = (state_q == IF_STATE_HALTED);
   assign pc_plus1  = pc_q + IM_ADDR_NBIT'(1);

   pst_if_pc_gen #(
      .IM_ADDR_NBIT (IM_ADDR_NBIT)
   ) u_pc_gen (
      .pc_i           (pc_q),
      .redirect_vld_i (redirect_vld),
      .redirect_pc_i  (redirect_pc),
      .halt_req_i     (halt_req),
      .stall_i        (stall),
      .state_i        (state_q),
      .pc_next_o      (pc_d)
   );

   // FSM next state: halt from RUN unless redirected; wake on resume or redirect.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IF_STATE_RUN:    if (halt_req && !redirect_vld) state_d = IF_STATE_HALTED;
         IF_STATE_HALTED: if (resume || redirect_vld)    state_d = IF_STATE_RUN;
         default:         state_d = IF_STATE_RUN;
      endcase
   end

   // IF/ID load decode: redirect/flush bubble beats stall hold beats halt bubble.
   always_comb begin
      ld_bubble = 1'b0;
      ld_real   = 1'b0;
      if (redirect_vld || flush_id) begin
         ld_bubble = 1'b1;
      end else if (stall) begin
         ld_bubble = 1'b0;
      end else if (is_halted || halt_req) begin
         ld_bubble = 1'b1;
      end else begin
         ld_real = 1'b1;
      end
   end

   // PC, FSM and IF/ID register; every update is gated by en.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every pipeline register here has an explicit reset value because
      // decode consumes id_* directly after reset release.
      if (rst) begin
         pc_q         <= RESET_PC;
         state_q      <= IF_STATE_RUN;
         id_pc_q      <= '0;
         id_pc_next_q <= '0;
         id_inst_q    <= NOP_INST;
         id_vld_q     <= 1'b0;
      end else if (en) begin
         // NOTE: non-blocking assignments so all registers sample the values
         // from before this edge, independent of statement order.
         pc_q    <= pc_d;
         state_q <= state_d;
         if (ld_bubble) begin
            id_pc_q      <= pc_q;
            id_pc_next_q <= pc_plus1;
            id_inst_q    <= NOP_INST;
            id_vld_q     <= 1'b0;
         end else if (ld_real) begin
            id_pc_q      <= pc_q;
            id_pc_next_q <= pc_plus1;
            id_inst_q    <= im_data;
            id_vld_q     <= 1'b1;
         end
      end
   end

`ifdef PST_IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_bubble_q;

   // Count real and bubble IF/ID loads; stall holds count as neither.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_q  <= '0;
         perf_bubble_q <= '0;
      end else if (en) begin
         if (ld_real)   perf_fetch_q  <= perf_fetch_q + 32'd1;
         if (ld_bubble) perf_bubble_q <= perf_bubble_q + 32'd1;
      end
   end

   assign perf_fetch  = perf_fetch_q;
   assign perf_bubble = perf_bubble_q;
`endif

   assign im_addr    = pc_q;
   assign id_pc      = id_pc_q;
   assign id_pc_next = id_pc_next_q;
   assign id_inst    = id_inst_q;
   assign id_vld     = id_vld_q;
   assign halted     = is_halted;

endmodule : pst_if

// File: tb/tb_pst_if.sv
// Directed self-checking bench for pst_if (IM_ADDR_NBIT=10, RESET_PC=0).
// Perf counter checks are compiled in when PST_IF_PERF_CNT_EN is defined.
module tb_pst_if;

   localparam int N = 10;

   logic          clk;
   logic          rst;
   logic          en;
   logic          stall;
   logic          flush_id;
   logic          redirect_vld;
   logic [N-1:0]  redirect_pc;
   logic          halt_req;
   logic          resume;
   logic [N-1:0]  im_addr;
   logic [31:0]   im_data;
   logic [N-1:0]  id_pc;
   logic [N-1:0]  id_pc_next;
   logic [31:0]   id_inst;
   logic          id_vld;
   logic          halted;
`ifdef PST_IF_PERF_CNT_EN
   logic [31:0]   perf_fetch;
   logic [31:0]   perf_bubble;
`endif

   int total = 0;
   int bad   = 0;

   pst_if #(
      .IM_ADDR_NBIT (N),
      .RESET_PC     ('0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .stall        (stall),
      .flush_id     (flush_id),
      .redirect_vld (redirect_vld),
      .redirect_pc  (redirect_pc),
      .halt_req     (halt_req),
      .resume       (resume),
      .im_addr      (im_addr),
      .im_data      (im_data),
      .id_pc        (id_pc),
      .id_pc_next   (id_pc_next),
      .id_inst      (id_inst),
      .id_vld       (id_vld),
      .halted       (halted)
`ifdef PST_IF_PERF_CNT_EN
      ,
      .perf_fetch   (perf_fetch),
      .perf_bubble  (perf_bubble)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model: each word encodes its own address.
   function automatic logic [31:0] inst_of(input logic [N-1:0] a);
      return 32'hC0DE_0000 | {22'd0, a};
   endfunction

   always_comb im_data = inst_of(im_addr);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One rising edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check im_addr and the IF/ID contents; bubbles expect id_inst=0.
   task automatic exp_if(input string tag, input logic [N-1:0] addr,
                         input logic [N-1:0] pc, input logic vld);
      check({tag, "_addr"}, 32'(im_addr), 32'(addr));
      check({tag, "_idpc"}, 32'(id_pc),   32'(pc));
      check({tag, "_vld"},  32'(id_vld),  32'(vld));
      check({tag, "_inst"}, id_inst, vld ? inst_of(pc) : 32'h0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; stall = 1'b0; flush_id = 1'b0;
      redirect_vld = 1'b0; redirect_pc = '0; halt_req = 1'b0; resume = 1'b0;
      #2;
      // Reset state.
      check("rst_addr",   32'(im_addr),    32'h0);
      check("rst_idpc",   32'(id_pc),      32'h0);
      check("rst_idnext", 32'(id_pc_next), 32'h0);
      check("rst_inst",   id_inst,         32'h0);
      check("rst_vld",    32'(id_vld),     32'h0);
      check("rst_halted", 32'(halted),     32'h0);
      step();
      rst = 1'b0; en = 1'b1;

      // Sequential fetch: id_* lags im_addr by one cycle.
      step(); exp_if("seq1", 10'd1, 10'd0, 1'b1);
      step(); exp_if("seq2", 10'd2, 10'd1, 1'b1);
      step(); exp_if("seq3", 10'd3, 10'd2, 1'b1);
      check("seq3_next", 32'(id_pc_next), 32'd3);
      step(); exp_if("seq4", 10'd4, 10'd3, 1'b1);
      step(); exp_if("seq5", 10'd5, 10'd4, 1'b1);

      // Stall at pc=5 for three cycles, then release.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(); exp_if("stall", 10'd5, 10'd4, 1'b1);
      end
      stall = 1'b0;
      step(); exp_if("unstall", 10'd6, 10'd5, 1'b1);
      step(); exp_if("seq7", 10'd7, 10'd6, 1'b1);
      step(); exp_if("seq8", 10'd8, 10'd7, 1'b1);

      // Redirect overrides stall at pc=8.
      stall = 1'b1; redirect_vld = 1'b1; redirect_pc = 10'h040;
      step(); exp_if("redir", 10'h040, 10'd8, 1'b0);
      stall = 1'b0; redirect_vld = 1'b0;
      step(); exp_if("redir_tgt", 10'h041, 10'h040, 1'b1);

      // Wrap at the top of the address space.
      redirect_vld = 1'b1; redirect_pc = 10'h3FE;
      step(); exp_if("wr_redir", 10'h3FE, 10'h041, 1'b0);
      redirect_vld = 1'b0;
      step(); exp_if("wr0", 10'h3FF, 10'h3FE, 1'b1);
      step(); exp_if("wr1", 10'h000, 10'h3FF, 1'b1);
      check("wr1_next", 32'(id_pc_next), 32'h0);
      step(); exp_if("wr2", 10'h001, 10'h000, 1'b1);

      // Halt at pc=12, halt_req in HALTED ignored, resume.
      redirect_vld = 1'b1; redirect_pc = 10'd12;
      step(); exp_if("h_redir", 10'd12, 10'd1, 1'b0);
      redirect_vld = 1'b0; halt_req = 1'b1;
      step(); exp_if("h_enter", 10'd12, 10'd12, 1'b0);
      check("h_enter_halted", 32'(halted), 32'd1);
      step(); exp_if("h_hold", 10'd12, 10'd12, 1'b0);
      check("h_hold_halted", 32'(halted), 32'd1);
      halt_req = 1'b0; resume = 1'b1;
      step(); exp_if("h_resume", 10'd12, 10'd12, 1'b0);
      check("h_resume_halted", 32'(halted), 32'd0);
      resume = 1'b0;
      step(); exp_if("h_after", 10'd13, 10'd12, 1'b1);

      // Halt, then wake with a redirect to 0x80.
      halt_req = 1'b1;
      step(); exp_if("h2_enter", 10'd13, 10'd13, 1'b0);
      check("h2_halted", 32'(halted), 32'd1);
      halt_req = 1'b0; redirect_vld = 1'b1; redirect_pc = 10'h080;
      step(); exp_if("h2_wake", 10'h080, 10'd13, 1'b0);
      check("h2_wake_halted", 32'(halted), 32'd0);
      redirect_vld = 1'b0;
      step(); exp_if("h2_after", 10'h081, 10'h080, 1'b1);

      // halt_req and resume together in RUN: halt wins.
      halt_req = 1'b1; resume = 1'b1;
      step(); exp_if("hr_both", 10'h081, 10'h081, 1'b0);
      check("hr_both_halted", 32'(halted), 32'd1);
      halt_req = 1'b0;
      step(); check("hr_res_halted", 32'(halted), 32'd0);
      check("hr_res_addr", 32'(im_addr), 32'h081);
      resume = 1'b0;
      step(); exp_if("hr_after", 10'h082, 10'h081, 1'b1);

      // Asynchronous reset mid-cycle, independent of en.
      #2; en = 1'b0; rst = 1'b1;
      #1;
      check("mrst_addr", 32'(im_addr), 32'h0);
      check("mrst_vld",  32'(id_vld),  32'h0);
      check("mrst_idpc", 32'(id_pc),   32'h0);
      step();
      rst = 1'b0; en = 1'b1;
`ifdef PST_IF_PERF_CNT_EN
      check("perf_rst_f", perf_fetch,  32'd0);
      check("perf_rst_b", perf_bubble, 32'd0);
`endif

      // Ten sequential fetches followed by one flush.
      for (int i = 1; i <= 10; i++) step();
      exp_if("p_seq", 10'd10, 10'd9, 1'b1);
      flush_id = 1'b1;
      step(); exp_if("p_flush", 10'd11, 10'd10, 1'b0);
      flush_id = 1'b0;
`ifdef PST_IF_PERF_CNT_EN
      check("perf_f10", perf_fetch,  32'd10);
      check("perf_b1",  perf_bubble, 32'd1);
`endif

      // en=0 for five cycles: everything holds, including the FSM.
      en = 1'b0; halt_req = 1'b1; redirect_vld = 1'b1; redirect_pc = 10'h200;
      for (int i = 0; i < 5; i++) step();
      exp_if("en0", 10'd11, 10'd10, 1'b0);
      check("en0_halted", 32'(halted), 32'd0);
`ifdef PST_IF_PERF_CNT_EN
      check("perf_en0_f", perf_fetch,  32'd10);
      check("perf_en0_b", perf_bubble, 32'd1);
`endif
      en = 1'b1; halt_req = 1'b0; redirect_vld = 1'b0;
      step(); exp_if("en1", 10'd12, 10'd11, 1'b1);
`ifdef PST_IF_PERF_CNT_EN
      check("perf_en1_f", perf_fetch, 32'd11);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pst_if
